fir_mac_sequencer: RTL

- Time-multiplexed FIR engine controller: one shared signed multiplier-accumulator is sequenced across N_TAPS taps per input sample.
- Holds a circular sample buffer and a coefficient register file. Coefficients are programmable over a narrow write port, sized for the 8-pin io_in / io_out budget of the gbsha_top wrapper.
- Sits between the top-level pin mux and the output pins. It replaces a fully parallel tap array.

---
 rtl/fir_mac_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_sequencer
// Brief    : Time-multiplexed FIR engine; one signed MAC walks N_TAPS taps
//            per accepted sample, then emits a saturated, shifted result.
// Revision : 1.0 - initial release
// ============================================================================
module fir_mac_sequencer #(
  parameter int N_TAPS  = 4,
  parameter int BW_in   = 6,
  parameter int BW_coef = 6,
  parameter int BW_out  = 8,
  parameter int SHIFT   = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [BW_in-1:0]     x_in,
  input  logic                        x_valid,
  output logic                        x_ready,
  input  logic signed [BW_coef-1:0]   coef_in,
  input  logic [$clog2(N_TAPS)-1:0]   coef_addr,
  input  logic                        coef_we,
  output logic signed [BW_out-1:0]    y_out,
  output logic                        y_valid,
  output logic                        busy
);

  localparam int c_aw    = $clog2(N_TAPS);
  localparam int c_pw    = BW_in + BW_coef;
  localparam int c_acc_w = c_pw + c_aw;
  localparam logic [c_aw-1:0]             c_k_last = c_aw'(N_TAPS - 1);
  localparam logic signed [c_acc_w-1:0]   c_y_max  = c_acc_w'((1 << (BW_out - 1)) - 1);
  localparam logic signed [c_acc_w-1:0]   c_y_min  = ~c_y_max;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic                         w_accept;
  logic                         w_mac;
  logic                         w_out;
  logic                         w_coef_wr;
  logic [c_aw-1:0]              r_wr_ptr;
  logic [c_aw-1:0]              r_k;
  logic [c_aw-1:0]              w_idx;
  logic signed [c_acc_w-1:0]    r_acc;
  logic signed [c_acc_w-1:0]    w_acc_sh;
  logic signed [c_pw-1:0]       w_prod;
  logic signed [c_acc_w-1:0]    w_prod_ext;
  logic signed [BW_out-1:0]     w_y_sat;
  logic signed [BW_out-1:0]     r_y_out;
  logic                         r_y_valid;
  logic signed [BW_in-1:0]      w_sample [N_TAPS];
  logic signed [BW_coef-1:0]    w_coef   [N_TAPS];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_mac       = 1'b0;
    w_out       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (x_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_MAC;
        end
      end
      S_MAC: begin
        w_mac = 1'b1;
        if (r_k == c_k_last) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        w_out       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign x_ready   = (r_state == S_IDLE);
  assign busy      = (r_state == S_MAC) || (r_state == S_OUT);
  assign w_coef_wr = coef_we && !busy;

  // ------------------------------------------------- sample / coef storage
  for (genvar i = 0; i < N_TAPS; i++) begin : g_tap
    logic signed [BW_in-1:0]   r_smp;
    logic signed [BW_coef-1:0] r_cf;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_smp <= '0;
        r_cf  <= '0;
      end else begin
        if (w_accept && (r_wr_ptr == c_aw'(i))) r_smp <= x_in;
        if (w_coef_wr && (coef_addr == c_aw'(i))) r_cf <= coef_in;
      end
    end

    assign w_sample[i] = r_smp;
    assign w_coef[i]   = r_cf;
  end

  // ------------------------------------------------------------ datapath
  // Unsigned wrap of the pointer difference gives the modulo-N_TAPS history index.
  assign w_idx      = r_wr_ptr - r_k;
  assign w_prod     = c_pw'(w_coef[r_k]) * c_pw'(w_sample[w_idx]);
  assign w_prod_ext = c_acc_w'(w_prod);
  assign w_acc_sh   = r_acc >>> SHIFT;
  assign w_y_sat    = (w_acc_sh > c_y_max) ? c_y_max[BW_out-1:0] :
                      (w_acc_sh < c_y_min) ? c_y_min[BW_out-1:0] :
                                             w_acc_sh[BW_out-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_k       <= '0;
      r_acc     <= '0;
      r_y_out   <= '0;
      r_y_valid <= 1'b0;
    end else begin
      r_y_valid <= w_out;
      if (w_accept) begin
        r_acc <= '0;
        r_k   <= '0;
      end
      if (w_mac) begin
        r_acc <= r_acc + w_prod_ext;
        r_k   <= r_k + 1'b1;
      end
      if (w_out) begin
        r_y_out  <= w_y_sat;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
    end
  end

  assign y_out   = r_y_out;
  assign y_valid = r_y_valid;

endmodule
`default_nettype wire
